ws2812b_frame_arbiter: RTL
==========================

// Module: ws2812b_frame_arbiter
// PURPOSE
//  Shares the 8x8 WS2812B matrix between two pixel writers (A, B). Owns a
//  64x24 back buffer and a 64x24 front buffer. The front buffer drives the
//  eight 192-bit row buses feeding the WS2812B serializer. The current
//  owner writes pixels, then commits. Back->front swap happens only while
//  the serializer reports its inter-frame gap, so frames never tear.
// PARAMETERS
//  TIMEOUT  500000  idle cycles (no WR/COMMIT) before the owner's grant is revoked
//  TO_W     20      width of the timeout counter; must hold TIMEOUT
// PORTS
//  CLK            in   1    system clock, all logic on posedge
//  RST            in   1    asynchronous, active-high reset
//  A_REQ          in   1    requester A wants ownership (level)
//  A_GNT          out  1    A owns the back buffer
//  A_WR           in   1    A pixel write strobe
//  A_ADDR         in   6    A pixel index: row=ADDR[5:3], col=ADDR[2:0]
//  A_RGB          in   24   A pixel word, stored unmodified
//  A_COMMIT       in   1    A requests back->front swap (1-cycle pulse)
//  B_REQ/B_GNT/B_WR/B_ADDR/B_RGB/B_COMMIT   same as A, for requester B
//  SWAP_OK        in   1    high while the serializer is in its latch/reset gap
//  RGB_DATA_01..08 out [0:191] front buffer rows 0..7
//                 LED col c at bits [c*24 +: 24]; word bit 23 lands on the lowest index
//  FRAME_DONE     out  1    1-cycle pulse on the cycle after a swap
//  BUSY           out  1    high in SWAP_WAIT
//  ERR            out  1    1-cycle pulse: WR or COMMIT from a non-owner, or during SWAP_WAIT
// BEHAVIOUR
//  Reset: both buffers all-zero; A_GNT, B_GNT, FRAME_DONE, BUSY and ERR are 0;
//   state IDLE; last_owner=B, so A wins first.
//  FSM states: IDLE, OWN_A, OWN_B, SWAP_WAIT. GNT is registered: it rises 1 cycle
//   after REQ is seen in IDLE.
//  IDLE
//   - If exactly one REQ is high, grant that requester.
//   - If both are high, grant the requester that is not last_owner (round-robin).
//  OWN_x
//   - x_WR writes x_RGB into back[x_ADDR] the same cycle; the data is visible
//     in the back buffer next cycle.
//   - x_COMMIT -> SWAP_WAIT. The GNT for x stays high; a WR in the same cycle
//     as COMMIT is still written first.
//   - x_REQ low -> IDLE; GNT drops next cycle; last_owner=x; the back buffer
//     keeps its contents.
//   - Timeout counter: cleared by each WR or COMMIT and on entry to OWN_x.
//     Reaching TIMEOUT -> IDLE, GNT dropped, last_owner=x, uncommitted data kept.
//   - The non-owner's WR or COMMIT is ignored and pulses ERR.
//  SWAP_WAIT
//   - Timeout counter is frozen. All WR and COMMIT inputs are ignored and pulse ERR.
//   - On the first cycle with SWAP_OK=1, all 1536 bits copy back->front in one cycle.
//   - FRAME_DONE pulses the next cycle.
//   - Next state: OWN_x if x_REQ is still high, else IDLE with GNT dropped.
//   - SWAP_OK already high on entry: the swap happens on the next cycle (1-cycle
//     minimum latency from COMMIT to swap).
//   - x_REQ dropping while waiting does not cancel the pending swap.
//  Front buffer changes only at a swap. The back buffer is never cleared
//   except by reset.
//  Address decode: all 64 addresses are valid; there is no wrap or out-of-range case.
//  RST during SWAP_WAIT: the swap is aborted; both buffers return to zero.
// TESTING
//  T1 reset; A_REQ=1; write addr0=24'hFF0000, addr63=24'h0000FF; commit; SWAP_OK=1
//     -> RGB_DATA_01[0:23]=FF0000, RGB_DATA_08[168:191]=0000FF, one FRAME_DONE pulse
//  T2 A_REQ and B_REQ rise in the same cycle after reset -> A_GNT; A releases
//     -> B_GNT; both request again -> A_GNT (round-robin)
//  T3 A owns; B_WR addr5=24'h123456 -> ERR pulse; back and front buffers unchanged
//  T4 commit while SWAP_OK=0 for 100 cycles -> BUSY=1, front unchanged,
//     A_WR pulses ERR; SWAP_OK=1 -> swap, BUSY=0
//  T5 TIMEOUT=16; A idle 16 cycles -> A_GNT=0, waiting B_GNT=1 next cycle;
//     B commits -> front shows A's uncommitted pixels
//  T6 RST asserted in SWAP_WAIT -> all outputs 0, front all-zero, no FRAME_DONE pulse

Source files
------------

// File: rtl/ws2812b_frame_arbiter.sv
// ws2812b_frame_arbiter: two-writer arbiter for an 8x8 WS2812B matrix.
// The owner fills a 64x24 back buffer; a commit copies it into the front
// buffer during the serializer's inter-frame gap, so frames never tear.
module ws2812b_frame_arbiter #(
  parameter int unsigned TIMEOUT = 500000,
  parameter int unsigned TO_W    = 20
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         A_REQ,
  output logic         A_GNT,
  input  logic         A_WR,
  input  logic [5:0]   A_ADDR,
  input  logic [23:0]  A_RGB,
  input  logic         A_COMMIT,
  input  logic         B_REQ,
  output logic         B_GNT,
  input  logic         B_WR,
  input  logic [5:0]   B_ADDR,
  input  logic [23:0]  B_RGB,
  input  logic         B_COMMIT,
  input  logic         SWAP_OK,
  output logic [0:191] RGB_DATA_01,
  output logic [0:191] RGB_DATA_02,
  output logic [0:191] RGB_DATA_03,
  output logic [0:191] RGB_DATA_04,
  output logic [0:191] RGB_DATA_05,
  output logic [0:191] RGB_DATA_06,
  output logic [0:191] RGB_DATA_07,
  output logic [0:191] RGB_DATA_08,
  output logic         FRAME_DONE,
  output logic         BUSY,
  output logic         ERR
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, SWAP_WAIT} state_t;

  state_t            r_state;
  logic              r_a_gnt;
  logic              r_b_gnt;
  logic              r_last_b;   // last owner was B
  logic              r_swap_b;   // pending swap was committed by B
  logic [TO_W-1:0]   r_to;
  logic              r_done;
  logic              r_busy;
  logic              r_err;
  logic [23:0]       r_back  [64];
  logic [23:0]       r_front [64];

  logic              w_own_a;
  logic              w_own_b;
  logic              w_we;
  logic [5:0]        w_waddr;
  logic [23:0]       w_wdata;
  logic              w_req;
  logic              w_commit;
  logic              w_act;
  logic              w_to_hit;
  logic              w_swap;
  logic              w_err;
  logic [0:191]      w_rows [8];

  assign w_own_a  = (r_state == OWN_A);
  assign w_own_b  = (r_state == OWN_B);
  assign w_we     = (w_own_a & A_WR) | (w_own_b & B_WR);
  assign w_waddr  = w_own_b ? B_ADDR : A_ADDR;
  assign w_wdata  = w_own_b ? B_RGB  : A_RGB;
  assign w_req    = w_own_b ? B_REQ  : A_REQ;
  assign w_commit = w_own_b ? B_COMMIT : A_COMMIT;
  assign w_act    = w_own_b ? (B_WR | B_COMMIT) : (A_WR | A_COMMIT);
  assign w_to_hit = (r_to == TO_W'(TIMEOUT - 1));
  assign w_swap   = (r_state == SWAP_WAIT) && SWAP_OK;

  // Flag writes/commits from anyone who does not currently own the buffer
  always_comb begin
    w_err = 1'b0;
    case (r_state)
      OWN_A:   w_err = B_WR | B_COMMIT;
      OWN_B:   w_err = A_WR | A_COMMIT;
      default: w_err = A_WR | A_COMMIT | B_WR | B_COMMIT;
    endcase
  end

  // Ownership FSM with registered grant/status outputs and idle timeout
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= IDLE;
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_last_b <= 1'b1;
      r_swap_b <= 1'b0;
      r_to     <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_err  <= w_err;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (A_REQ && (!B_REQ || r_last_b)) begin
            r_state <= OWN_A;
            r_a_gnt <= 1'b1;
            r_to    <= '0;
          end else if (B_REQ) begin
            r_state <= OWN_B;
            r_b_gnt <= 1'b1;
            r_to    <= '0;
          end
        end
        OWN_A, OWN_B: begin
          if (w_commit) begin
            r_state  <= SWAP_WAIT;
            r_busy   <= 1'b1;
            r_swap_b <= w_own_b;
            r_to     <= '0;
          end else if (!w_req || (!w_act && w_to_hit)) begin
            r_state  <= IDLE;
            r_a_gnt  <= 1'b0;
            r_b_gnt  <= 1'b0;
            r_last_b <= w_own_b;
          end else if (w_act) begin
            r_to <= '0;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        SWAP_WAIT: begin
          if (SWAP_OK) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
            if (r_swap_b ? B_REQ : A_REQ) begin
              r_state <= r_swap_b ? OWN_B : OWN_A;
              r_to    <= '0;
            end else begin
              r_state  <= IDLE;
              r_a_gnt  <= 1'b0;
              r_b_gnt  <= 1'b0;
              r_last_b <= r_swap_b;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Back buffer: owner pixel writes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_back <= '{default: '0};
    end else if (w_we) begin
      r_back[w_waddr] <= w_wdata;
    end
  end

  // Front buffer: whole-frame copy during the serializer gap
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_front <= '{default: '0};
    end else if (w_swap) begin
      r_front <= r_back;
    end
  end

  // Row buses: column c occupies [c*24 +: 24], pixel MSB on the lowest index
  for (genvar gr = 0; gr < 8; gr++) begin : g_row
    for (genvar gc = 0; gc < 8; gc++) begin : g_col
      assign w_rows[gr][gc*24 +: 24] = r_front[gr*8 + gc];
    end
  end

  assign RGB_DATA_01 = w_rows[0];
  assign RGB_DATA_02 = w_rows[1];
  assign RGB_DATA_03 = w_rows[2];
  assign RGB_DATA_04 = w_rows[3];
  assign RGB_DATA_05 = w_rows[4];
  assign RGB_DATA_06 = w_rows[5];
  assign RGB_DATA_07 = w_rows[6];
  assign RGB_DATA_08 = w_rows[7];

  assign A_GNT      = r_a_gnt;
  assign B_GNT      = r_b_gnt;
  assign FRAME_DONE = r_done;
  assign BUSY       = r_busy;
  assign ERR        = r_err;

endmodule
